// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: forwards ALU results or runs a req/ack data-memory
// access while stalling upstream. Optional BUSY watchdog under `MEM_TIMEOUT_EN.
module mem_stage_ctrl #(
  parameter int DATA_WIDTH     = 64,
  parameter int REG_ADDR_WIDTH = 3,
  parameter int ADDR_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      w_reg_en,
  input  logic                      w_mem_en,
  input  logic                      mem_rd_en,
  input  logic [DATA_WIDTH-1:0]     r1_out,
  input  logic [DATA_WIDTH-1:0]     r2_out,
  input  logic [REG_ADDR_WIDTH-1:0] w_reg_1,
  output logic                      dmem_req,
  output logic                      dmem_we,
  output logic [ADDR_WIDTH-1:0]     dmem_addr,
  output logic [DATA_WIDTH-1:0]     dmem_wdata,
  input  logic                      dmem_ack,
  input  logic [DATA_WIDTH-1:0]     dmem_rdata,
  output logic                      stall,
  output logic                      wb_reg_en,
  output logic [REG_ADDR_WIDTH-1:0] wb_reg_addr,
  output logic [DATA_WIDTH-1:0]     wb_data,
  output logic                      mem_err
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e                    state_q, state_d;
  logic                      dmem_req_q, dmem_req_d;
  logic                      dmem_we_q, dmem_we_d;
  logic [ADDR_WIDTH-1:0]     dmem_addr_q, dmem_addr_d;
  logic [DATA_WIDTH-1:0]     dmem_wdata_q, dmem_wdata_d;
  logic                      pend_wr_q, pend_wr_d;
  logic [REG_ADDR_WIDTH-1:0] pend_reg_q, pend_reg_d;
  logic                      wb_reg_en_q, wb_reg_en_d;
  logic [REG_ADDR_WIDTH-1:0] wb_reg_addr_q, wb_reg_addr_d;
  logic [DATA_WIDTH-1:0]     wb_data_q, wb_data_d;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] busy_cnt_q, busy_cnt_d;
  logic             mem_err_q, mem_err_d;
`endif

  logic is_mem_op;
  assign is_mem_op = w_mem_en | mem_rd_en;

  always_comb begin
    // NOTE: every _d starts as its _q so no path through this block leaves a
    // signal unassigned, which would otherwise infer a latch.
    state_d       = state_q;
    dmem_req_d    = dmem_req_q;
    dmem_we_d     = dmem_we_q;
    dmem_addr_d   = dmem_addr_q;
    dmem_wdata_d  = dmem_wdata_q;
    pend_wr_d     = pend_wr_q;
    pend_reg_d    = pend_reg_q;
    wb_reg_en_d   = wb_reg_en_q;
    wb_reg_addr_d = wb_reg_addr_q;
    wb_data_d     = wb_data_q;
`ifdef MEM_TIMEOUT_EN
    busy_cnt_d    = busy_cnt_q;
    mem_err_d     = mem_err_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (enable && is_mem_op) begin
          // A store wins when both store and load flags are raised.
          dmem_req_d   = 1'b1;
          dmem_we_d    = w_mem_en;
          dmem_addr_d  = r1_out[ADDR_WIDTH-1:0];
          dmem_wdata_d = r2_out;
          pend_wr_d    = w_reg_en;
          pend_reg_d   = w_reg_1;
          wb_reg_en_d  = 1'b0;
          state_d      = BUSY;
`ifdef MEM_TIMEOUT_EN
          busy_cnt_d   = '0;
`endif
        end else if (enable) begin
          wb_reg_en_d   = w_reg_en;
          wb_reg_addr_d = w_reg_1;
          wb_data_d     = r1_out;
        end else begin
          wb_reg_en_d = 1'b0;
        end
      end

      BUSY: begin
        wb_reg_en_d = 1'b0;
        if (dmem_ack) begin
          dmem_req_d = 1'b0;
          state_d    = IDLE;
          if (!dmem_we_q) begin
            wb_reg_en_d   = pend_wr_q;
            wb_reg_addr_d = pend_reg_q;
            wb_data_d     = dmem_rdata;
          end
`ifdef MEM_TIMEOUT_EN
        end else if (busy_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          // Limit reached without ack: squash the instruction and flag it.
          dmem_req_d = 1'b0;
          state_d    = IDLE;
          mem_err_d  = 1'b1;
        end else begin
          busy_cnt_d = busy_cnt_q + 1'b1;
`endif
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  // NOTE: datapath registers are reset too, since every output must read 0
  // straight out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      dmem_req_q    <= 1'b0;
      dmem_we_q     <= 1'b0;
      dmem_addr_q   <= '0;
      dmem_wdata_q  <= '0;
      pend_wr_q     <= 1'b0;
      pend_reg_q    <= '0;
      wb_reg_en_q   <= 1'b0;
      wb_reg_addr_q <= '0;
      wb_data_q     <= '0;
`ifdef MEM_TIMEOUT_EN
      busy_cnt_q    <= '0;
      mem_err_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      dmem_req_q    <= dmem_req_d;
      dmem_we_q     <= dmem_we_d;
      dmem_addr_q   <= dmem_addr_d;
      dmem_wdata_q  <= dmem_wdata_d;
      pend_wr_q     <= pend_wr_d;
      pend_reg_q    <= pend_reg_d;
      wb_reg_en_q   <= wb_reg_en_d;
      wb_reg_addr_q <= wb_reg_addr_d;
      wb_data_q     <= wb_data_d;
`ifdef MEM_TIMEOUT_EN
      busy_cnt_q    <= busy_cnt_d;
      mem_err_q     <= mem_err_d;
`endif
    end
  end

  assign stall       = (state_q == BUSY);
  assign dmem_req    = dmem_req_q;
  assign dmem_we     = dmem_we_q;
  assign dmem_addr   = dmem_addr_q;
  assign dmem_wdata  = dmem_wdata_q;
  assign wb_reg_en   = wb_reg_en_q;
  assign wb_reg_addr = wb_reg_addr_q;
  assign wb_data     = wb_data_q;
`ifdef MEM_TIMEOUT_EN
  assign mem_err     = mem_err_q;
`else
  assign mem_err     = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: a transaction-level reference model is
// compared every cycle, plus hand-computed literal checks per scenario.
module tb_mem_stage_ctrl;

  localparam int DW  = 64;
  localparam int RW  = 3;
  localparam int AW  = 8;
  localparam int TOC = 16;
`ifdef MEM_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0, w_reg_en = 1'b0, w_mem_en = 1'b0, mem_rd_en = 1'b0;
  logic [DW-1:0] r1_out = '0, r2_out = '0, dmem_rdata = '0;
  logic [RW-1:0] w_reg_1 = '0;
  logic          dmem_ack = 1'b0;
  logic          dmem_req, dmem_we, stall, wb_reg_en, mem_err;
  logic [AW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata, wb_data;
  logic [RW-1:0] wb_reg_addr;

  mem_stage_ctrl #(
    .DATA_WIDTH(DW), .REG_ADDR_WIDTH(RW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TOC)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .w_reg_en(w_reg_en),
    .w_mem_en(w_mem_en), .mem_rd_en(mem_rd_en), .r1_out(r1_out), .r2_out(r2_out),
    .w_reg_1(w_reg_1), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .stall(stall), .wb_reg_en(wb_reg_en), .wb_reg_addr(wb_reg_addr),
    .wb_data(wb_data), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit cmp_on = 1'b0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding access plus the last write-back result.
  typedef struct {
    bit            in_flight;
    bit            is_store;
    bit            wants_wb;
    logic [RW-1:0] dest;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            waited;
  } access_t;

  access_t       acc = '{default: '0};
  bit            m_wb_en = 1'b0;
  logic [RW-1:0] m_wb_addr = '0;
  logic [DW-1:0] m_wb_data = '0;
  bit            m_err = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      acc       <= '{default: '0};
      m_wb_en   <= 1'b0;
      m_wb_addr <= '0;
      m_wb_data <= '0;
      m_err     <= 1'b0;
    end else if (!acc.in_flight) begin
      if (enable && (w_mem_en || mem_rd_en)) begin
        acc     <= '{1'b1, w_mem_en, w_reg_en, w_reg_1, r1_out[AW-1:0], r2_out, 0};
        m_wb_en <= 1'b0;
      end else begin
        m_wb_en <= enable && w_reg_en;
        if (enable) begin
          m_wb_addr <= w_reg_1;
          m_wb_data <= r1_out;
        end
      end
    end else if (dmem_ack) begin
      acc.in_flight <= 1'b0;
      m_wb_en       <= !acc.is_store && acc.wants_wb;
      if (!acc.is_store) begin
        m_wb_addr <= acc.dest;
        m_wb_data <= dmem_rdata;
      end
    end else if (TO_EN && acc.waited + 1 == TOC) begin
      acc.in_flight <= 1'b0;
      m_wb_en       <= 1'b0;
      m_err         <= 1'b1;
    end else begin
      acc.waited <= acc.waited + 1;
      m_wb_en    <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      check("cyc_req",    dmem_req,    acc.in_flight);
      check("cyc_stall",  stall,       acc.in_flight);
      check("cyc_we",     dmem_we,     acc.is_store);
      check("cyc_addr",   dmem_addr,   acc.addr);
      check("cyc_wdata",  dmem_wdata,  acc.wdata);
      check("cyc_wb_en",  wb_reg_en,   m_wb_en);
      check("cyc_wb_adr", wb_reg_addr, m_wb_addr);
      check("cyc_wb_dat", wb_data,     m_wb_data);
      check("cyc_err",    mem_err,     m_err);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    enable    = 1'b0;
    w_mem_en  = 1'b0;
    mem_rd_en = 1'b0;
    w_reg_en  = 1'b0;
  endtask

  // Presents one memory instruction, holds it while stalled, acks in BUSY cycle k.
  task automatic mem_op(input bit st, input bit ld, input bit wen, input logic [RW-1:0] dst,
                        input logic [DW-1:0] addr, input logic [DW-1:0] wd, input int k,
                        input logic [DW-1:0] rdata);
    logic [AW-1:0] a8;
    a8 = addr[AW-1:0];
    enable = 1'b1; w_mem_en = st; mem_rd_en = ld; w_reg_en = wen;
    w_reg_1 = dst; r1_out = addr; r2_out = wd;
    tick();
    for (int i = 1; i <= k; i++) begin
      @(negedge clk);
      check("op_req",   dmem_req,   1);
      check("op_we",    dmem_we,    st);
      check("op_addr",  dmem_addr,  a8);
      check("op_wdata", dmem_wdata, wd);
      check("op_stall", stall,      1);
      check("op_wb_en", wb_reg_en,  0);
      if (i == k) begin
        dmem_ack   = 1'b1;
        dmem_rdata = rdata;
      end
      tick();
    end
    dmem_ack = 1'b0;
    idle_inputs();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 reset = 1'b1;
    #2 cmp_on = 1'b1;
    @(negedge clk);
    check("rst_req",   dmem_req,  0);
    check("rst_stall", stall,     0);
    check("rst_wb_en", wb_reg_en, 0);
    check("rst_data",  wb_data,   0);
    check("rst_err",   mem_err,   0);
    @(posedge clk); #2 reset = 1'b0;

    // Pass-through then bubble.
    enable = 1'b1; w_reg_en = 1'b1; w_reg_1 = 3'd3; r1_out = 64'h55;
    tick();
    idle_inputs();
    @(negedge clk);
    check("pt_wb_en",  wb_reg_en,   1);
    check("pt_wb_adr", wb_reg_addr, 3);
    check("pt_wb_dat", wb_data,     64'h55);
    check("pt_stall",  stall,       0);
    dmem_ack = 1'b1;  // ack while IDLE must be ignored
    tick();
    dmem_ack = 1'b0;
    @(negedge clk);
    check("bub_wb_en", wb_reg_en, 0);
    check("bub_req",   dmem_req,  0);
    tick();

    // Store with 3-cycle ack delay.
    mem_op(1'b1, 1'b0, 1'b0, 3'd0, 64'h1A, 64'hDEAD, 3, 64'h0);
    @(negedge clk);
    check("st_req",   dmem_req,  0);
    check("st_stall", stall,     0);
    check("st_wb_en", wb_reg_en, 0);
    check("st_addr",  dmem_addr, 8'h1A);
    tick();

    // Zero-wait load.
    mem_op(1'b0, 1'b1, 1'b1, 3'd5, 64'h40, 64'h0, 1, 64'hBEEF);
    @(negedge clk);
    check("ld_wb_en",  wb_reg_en,   1);
    check("ld_wb_adr", wb_reg_addr, 5);
    check("ld_wb_dat", wb_data,     64'hBEEF);
    check("ld_req",    dmem_req,    0);
    tick();

    // Back-to-back loads with a single low req cycle between them.
    mem_op(1'b0, 1'b1, 1'b1, 3'd2, 64'h01, 64'h0, 2, 64'h111);
    @(negedge clk);
    check("b2b_gap_req", dmem_req,    0);
    check("b2b_a_adr",   wb_reg_addr, 2);
    check("b2b_a_dat",   wb_data,     64'h111);
    mem_op(1'b0, 1'b1, 1'b1, 3'd6, 64'h02, 64'h0, 1, 64'h222);
    @(negedge clk);
    check("b2b_b_en",  wb_reg_en,   1);
    check("b2b_b_adr", wb_reg_addr, 6);
    check("b2b_b_dat", wb_data,     64'h222);

    // Both flags set behaves as a store: no write-back.
    mem_op(1'b1, 1'b1, 1'b1, 3'd7, 64'h33, 64'hCAFE, 1, 64'h999);
    @(negedge clk);
    check("both_wb_en", wb_reg_en, 0);
    check("both_dat",   wb_data,   64'h222);
    tick();

    // Reset mid-BUSY, late ack ignored.
    enable = 1'b1; mem_rd_en = 1'b1; w_reg_en = 1'b1; w_reg_1 = 3'd4; r1_out = 64'h77;
    tick();
    @(negedge clk);
    check("rb_req", dmem_req, 1);
    @(posedge clk); #2;
    reset = 1'b1;
    idle_inputs();
    #1;
    check("rb_req0",   dmem_req,   0);
    check("rb_stall0", stall,      0);
    check("rb_addr0",  dmem_addr,  0);
    check("rb_wdat0",  dmem_wdata, 0);
    check("rb_dat0",   wb_data,    0);
    @(posedge clk); #2 reset = 1'b0;
    tick();
    dmem_ack = 1'b1; dmem_rdata = 64'hAAA;
    tick();
    dmem_ack = 1'b0;
    @(negedge clk);
    check("rb_ack_wb", wb_reg_en, 0);
    check("rb_ack_rq", dmem_req,  0);
    tick();

    // Load never acked for TIMEOUT_CYCLES BUSY cycles.
    enable = 1'b1; mem_rd_en = 1'b1; w_reg_en = 1'b1; w_reg_1 = 3'd1; r1_out = 64'h10;
    tick();
    repeat (TOC) tick();
`ifdef MEM_TIMEOUT_EN
    idle_inputs();
    @(negedge clk);
    check("to_req",   dmem_req,  0);
    check("to_stall", stall,     0);
    check("to_err",   mem_err,   1);
    check("to_wb_en", wb_reg_en, 0);
    repeat (3) tick();
    check("to_sticky", mem_err, 1);
    // Ack on the limit cycle completes normally.
    mem_op(1'b0, 1'b1, 1'b1, 3'd2, 64'h20, 64'h0, TOC, 64'h5A5A);
    @(negedge clk);
    check("lim_wb_en", wb_reg_en, 1);
    check("lim_dat",   wb_data,   64'h5A5A);
    check("lim_err",   mem_err,   1);
`else
    @(negedge clk);
    check("nt_req",   dmem_req, 1);
    check("nt_stall", stall,    1);
    check("nt_err",   mem_err,  0);
    dmem_ack = 1'b1; dmem_rdata = 64'h5A5A;
    tick();
    dmem_ack = 1'b0;
    idle_inputs();
    @(negedge clk);
    check("nt_wb_en", wb_reg_en,   1);
    check("nt_wb_adr", wb_reg_addr, 1);
    check("nt_dat",   wb_data,     64'h5A5A);
`endif
    tick();
    tick();
    cmp_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
